flit_link_delay: RTL and testbench

- Models one inter-router link: consumes the Router output stream (flit_out/flit_out_valid/nexthop_out, returns dequeue) and replays each flit to the downstream Router flit_in port after a configurable link latency measured in simulation time.
- Holds flits in a small FIFO stamped with their release time.
- Reports quiescence and time-advance readiness to the global sim-time controller.

---
 rtl/flit_link_delay.sv | 114 +++++++++++
 tb/tb_flit_link_delay.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/flit_link_delay.sv
// Inter-router link model: flits are held in a timestamped FIFO and replayed LATENCY sim-time ticks later (min 1 cycle).
// Upstream is stalled via in_dequeue when full; head-of-line blocks until acked. LINK_STATS_EN adds flit_count/max_occupancy.
module flit_link_delay #(
  parameter int FW      = 36,
  parameter int AW      = 8,
  parameter int TW      = 10,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [TW-1:0]            sim_time,
  input  logic [FW-1:0]            in_flit,
  input  logic                     in_valid,
  input  logic [AW-1:0]            in_nexthop,
  output logic                     in_dequeue,
  output logic [FW-1:0]            out_flit,
  output logic [AW-1:0]            out_nexthop,
  output logic                     out_valid,
  input  logic                     out_ack,
  output logic                     is_quiescent,
  output logic                     can_increment,
`ifdef LINK_STATS_EN
  output logic [15:0]              flit_count,
  output logic [$clog2(DEPTH):0]   max_occupancy,
`endif
  output logic                     error
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [FW-1:0] flit_mem [DEPTH];
  logic [AW-1:0] nh_mem   [DEPTH];
  logic [TW-1:0] ts_mem   [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic [TW-1:0] time_q;
  logic [TW-1:0] new_ts, head_diff, old_diff, new_diff;
  logic          full, empty, push, pop, ready, causal_err;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // All timestamp comparisons are done on the modular difference so they survive sim_time wrap.
  assign new_ts    = sim_time + TW'(LATENCY);
  assign new_diff  = sim_time - new_ts;
  assign head_diff = sim_time - ts_mem[rd_ptr];
  assign old_diff  = time_q - ts_mem[rd_ptr];
  assign ready     = ~empty & ~head_diff[TW-1];

  // Gated by reset so no handshake is offered while the link is being flushed.
  assign push       = reset & enable & in_valid & ~full;
  assign pop        = enable & ready & out_ack;
  assign in_dequeue = push;
  assign out_valid  = enable & ready;

  assign out_flit      = empty ? '0 : flit_mem[rd_ptr];
  assign out_nexthop   = empty ? '0 : nh_mem[rd_ptr];
  assign is_quiescent  = empty;
  assign can_increment = ~ready;

  // A stalled flit that is already due, or a time step past a flit that was due before the step.
  assign causal_err = (enable & in_valid & full & ~new_diff[TW-1]) |
                      (~empty & (sim_time != time_q) & ~old_diff[TW-1]);

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      time_q <= '0;
      error  <= 1'b0;
    end else begin
      time_q <= sim_time;
      count  <= count_next;
      if (push)       wr_ptr <= wr_ptr + 1'b1;
      if (pop)        rd_ptr <= rd_ptr + 1'b1;
      if (causal_err) error  <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      flit_mem[wr_ptr] <= in_flit;
      nh_mem[wr_ptr]   <= in_nexthop;
      ts_mem[wr_ptr]   <= new_ts;
    end
  end

`ifdef LINK_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      flit_count    <= '0;
      max_occupancy <= '0;
    end else begin
      if (pop && flit_count != 16'hFFFF) flit_count <= flit_count + 16'd1;
      if (count_next > max_occupancy)    max_occupancy <= count_next;
    end
  end
`endif

endmodule

// File: tb/tb_flit_link_delay.sv
// Scoreboard bench for flit_link_delay: directed scenarios followed by a randomized causal run.
module tb_flit_link_delay;
  localparam int FW = 36, AW = 8, TW = 10, DEPTH = 4, LAT = 3;
  localparam int TMOD = 1 << TW;

  logic          clock = 1'b0, reset = 1'b0, enable = 1'b0;
  logic [TW-1:0] sim_time = '0;
  logic [FW-1:0] in_flit = '0;
  logic [AW-1:0] in_nexthop = '0;
  logic          in_valid = 1'b0, out_ack = 1'b0;
  logic          in_dequeue, out_valid, is_quiescent, can_increment, error;
  logic [FW-1:0] out_flit;
  logic [AW-1:0] out_nexthop;
`ifdef LINK_STATS_EN
  logic [15:0]            flit_count;
  logic [$clog2(DEPTH):0] max_occupancy;
`endif

  flit_link_delay #(.FW(FW), .AW(AW), .TW(TW), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clock(clock), .reset(reset), .enable(enable), .sim_time(sim_time),
    .in_flit(in_flit), .in_valid(in_valid), .in_nexthop(in_nexthop), .in_dequeue(in_dequeue),
    .out_flit(out_flit), .out_nexthop(out_nexthop), .out_valid(out_valid), .out_ack(out_ack),
    .is_quiescent(is_quiescent), .can_increment(can_increment),
`ifdef LINK_STATS_EN
    .flit_count(flit_count), .max_occupancy(max_occupancy),
`endif
    .error(error));

  always #5 clock = ~clock;

  typedef struct {
    logic [FW-1:0] f;
    logic [AW-1:0] nh;
    int            ts;
  } ent_t;

  ent_t q[$];
  int   compared = 0, mismatched = 0;
  bit   exp_err = 0;
  int   prev_time = 0, pops = 0, peak = 0;

  // A flit stamped ts is due at time t when t is at or after ts on the modular timeline.
  function automatic bit is_due(int t, int ts);
    return ((t - ts + TMOD) % TMOD) < (TMOD / 2);
  endfunction

  function automatic bit head_due(int t);
    return (q.size() > 0) && is_due(t, q[0].ts);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor/scoreboard: compares outputs mid-cycle, then advances the model to the next edge.
  always @(negedge clock) begin : mon
    bit vld, acc;
    int t;
    t = int'(sim_time);
    if (!reset) begin
      q.delete();
      exp_err = 0; prev_time = 0; pops = 0; peak = 0;
      chk("rst_in_dequeue", in_dequeue, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_quiescent", is_quiescent, 1);
      chk("rst_can_increment", can_increment, 1);
      chk("rst_error", error, 0);
      chk("rst_out_flit", out_flit, 0);
      chk("rst_out_nexthop", out_nexthop, 0);
`ifdef LINK_STATS_EN
      chk("rst_flit_count", flit_count, 0);
      chk("rst_max_occupancy", max_occupancy, 0);
`endif
    end else begin
      vld = enable && head_due(t);
      acc = enable && in_valid && (q.size() < DEPTH);
      chk("in_dequeue", in_dequeue, acc);
      chk("out_valid", out_valid, vld);
      chk("is_quiescent", is_quiescent, q.size() == 0);
      chk("can_increment", can_increment, !head_due(t));
      chk("error", error, exp_err);
      chk("out_flit", out_flit, (q.size() > 0) ? q[0].f : '0);
      chk("out_nexthop", out_nexthop, (q.size() > 0) ? q[0].nh : '0);
`ifdef LINK_STATS_EN
      chk("flit_count", flit_count, (pops > 65535) ? 65535 : pops);
      chk("max_occupancy", max_occupancy, peak);
`endif
      if (enable && in_valid && q.size() == DEPTH && is_due(t, (t + LAT) % TMOD)) exp_err = 1;
      if (q.size() > 0 && t != prev_time && is_due(prev_time, q[0].ts)) exp_err = 1;
      prev_time = t;
      if (vld && out_ack) begin
        void'(q.pop_front());
        pops++;
      end
      if (acc) q.push_back('{f: in_flit, nh: in_nexthop, ts: (t + LAT) % TMOD});
      if (q.size() > peak) peak = q.size();
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push1(logic [FW-1:0] f, logic [AW-1:0] nh);
    in_flit = f; in_nexthop = nh; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    step(3);
    reset = 1'b1; enable = 1'b1;
    step(2);

    // basic latency: accepted at 10, due at 13
    sim_time = 10;
    push1(36'h0000000AB, 8'h05);
    sim_time = 11; step(2);
    sim_time = 12; step(2);
    sim_time = 13; step();
    out_ack = 1'b1; step(); out_ack = 1'b0;
    step(2);

    // full / backpressure: 5th flit waits for a pop
    sim_time = 20; in_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      in_flit = FW'(i); in_nexthop = AW'(i);
      step();
    end
    sim_time = 23; out_ack = 1'b1; step();
    out_ack = 1'b0; step();
    in_valid = 1'b0; out_ack = 1'b1; step(5);
    sim_time = 26; step(3); out_ack = 1'b0;

    // wrap-around: stamped 1, not due at 1023 or 0
    sim_time = 1022;
    push1(36'h123456789, 8'h3C);
    sim_time = 1023; step(2);
    sim_time = 0; step(2);
    sim_time = 1; step();
    out_ack = 1'b1; step(); out_ack = 1'b0;

    // simultaneous push and pop at count 2
    sim_time = 100;
    push1(36'hA, 8'h1A);
    push1(36'hB, 8'h1B);
    sim_time = 103; step();
    in_flit = 36'hC; in_nexthop = 8'h1C; in_valid = 1'b1; out_ack = 1'b1; step();
    in_valid = 1'b0; step(2);
    sim_time = 106; step(2); out_ack = 1'b0;

    // enable low freezes both sides
    sim_time = 300; enable = 1'b0; in_flit = 36'hE0; in_valid = 1'b1; out_ack = 1'b1;
    step(3);
    enable = 1'b1; step(); in_valid = 1'b0;
    sim_time = 303; enable = 1'b0; step(3);
    enable = 1'b1; step(); out_ack = 1'b0;

    // causality error: due flit left unacked while time advances
    sim_time = 400;
    push1(36'hC0FFEE, 8'h77);
    sim_time = 403; step(4);
    sim_time = 404; step(4);
    push1(36'hD1, 8'h78);
    push1(36'hD2, 8'h79);
    step();

    // async reset mid-cycle with 3 entries held
    @(posedge clock); #3;
    reset = 1'b0;
    #1;
    chk("midrst_quiescent", is_quiescent, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_error", error, 0);
`ifdef LINK_STATS_EN
    chk("midrst_flit_count", flit_count, 0);
`endif
    step(2);
    reset = 1'b1;
    step(2);

    // randomized run; time only advances when no flit is due
    sim_time = 500;
    for (int c = 0; c < 3000; c++) begin
      enable     = ($urandom_range(0, 9) != 0);
      in_valid   = $urandom_range(0, 1);
      in_flit    = {$urandom, $urandom} & {FW{1'b1}};
      in_nexthop = AW'($urandom);
      out_ack    = ($urandom_range(0, 2) != 0);
      if (!head_due(int'(sim_time)) && $urandom_range(0, 2) == 0) sim_time = sim_time + 1'b1;
      step();
    end
    in_valid = 1'b0; out_ack = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
